// File: rtl/control_sequencer_if.sv
// control_sequencer_if: fetch, decoder and datapath signals of the control sequencer
interface control_sequencer_if #(
    parameter int CW_WIDTH     = 33,
    parameter int RETIRE_WIDTH = 32
);
    logic                    ifetch_req;
    logic                    ifetch_ack;
    logic [31:0]             instr_in;
    logic                    mem_ready;
    logic [CW_WIDTH-1:0]     cw_in;
    logic [4:0]              status_in;
    logic [31:0]             I;
    logic [1:0]              state;
    logic [4:0]              status;
    logic [CW_WIDTH-1:0]     cw_out;
    logic                    executing;
    logic [RETIRE_WIDTH-1:0] retired;
    modport master (
        output ifetch_req, I, state, status, cw_out, executing, retired,
        input  ifetch_ack, instr_in, mem_ready, cw_in, status_in
    );
    modport slave (
        input  ifetch_req, I, state, status, cw_out, executing, retired,
        output ifetch_ack, instr_in, mem_ready, cw_in, status_in
    );
endinterface

// File: rtl/control_sequencer.sv
// control_sequencer: fetches instructions and steps decoder control words through execute sub-states
module control_sequencer #(
    parameter int CW_WIDTH     = 33,
    parameter int RETIRE_WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    control_sequencer_if.master  bus
);
    typedef enum logic [1:0] {BOOT, FETCH, EXEC} mode_t;
    localparam logic [CW_WIDTH-1:0] STALL_MASK = CW_WIDTH'(12'h234);
    mode_t                   r_mode;
    mode_t                   w_mode_nxt;
    logic                    w_stall;
    logic                    w_commit;
    logic                    w_done;
    logic                    w_load_i;
    logic [31:0]             r_I;
    logic [1:0]              r_state;
    logic [4:0]              r_status;
    logic [RETIRE_WIDTH-1:0] r_retired;
    // stall/commit decode, next mode and gated control word
    always_comb begin
        w_stall    = (r_mode == EXEC) && bus.cw_in[8] && !bus.mem_ready;
        w_commit   = (r_mode == EXEC) && !w_stall;
        w_done     = w_commit && (bus.cw_in[1:0] == 2'b00);
        w_load_i   = (r_mode == FETCH) && bus.ifetch_ack;
        w_mode_nxt = (r_mode == FETCH) ? (bus.ifetch_ack ? EXEC : FETCH) :
                     (r_mode == EXEC)  ? (w_done ? FETCH : EXEC) : FETCH;
        bus.cw_out = (r_mode != EXEC) ? '0 :
                     w_stall ? (bus.cw_in & ~STALL_MASK) : bus.cw_in;
    end
    assign bus.ifetch_req = (r_mode == FETCH);
    assign bus.executing  = (r_mode == EXEC);
    assign bus.I          = r_I;
    assign bus.state      = r_state;
    assign bus.status     = r_status;
    assign bus.retired    = r_retired;
    // mode register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_mode <= BOOT;
        else       r_mode <= w_mode_nxt;
    end
    // instruction, sub-state, status and retire registers; a stalled cycle holds them all
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_I       <= '0;
            r_state   <= '0;
            r_status  <= '0;
            r_retired <= '0;
        end else begin
            if (w_load_i) begin
                r_I     <= bus.instr_in;
                r_state <= 2'b00;
            end
            if (w_commit && bus.cw_in[2]) r_status <= bus.status_in;
            if (w_done) r_retired <= r_retired + RETIRE_WIDTH'(1);
            else if (w_commit) r_state <= bus.cw_in[1:0];
        end
    end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: table-driven cycle vectors with a scoreboard queue, plus an async reset sequence
module tb_control_sequencer;
    localparam logic [32:0] CW_A  = 33'h1_0000_1650;
    localparam logic [32:0] CW_B  = 33'h0_8030_0201;
    localparam logic [32:0] CW_C  = 33'h0_0000_0264;
    localparam logic [32:0] CW_L  = 33'h0_0020_1F54;
    localparam logic [32:0] CW_LS = 33'h0_0020_1D40;
    typedef struct {
        logic        ack;
        logic [31:0] instr;
        logic        mrdy;
        logic [32:0] cw;
        logic [4:0]  sin;
        logic        req;
        logic        ex;
        logic [32:0] cwo;
        logic [31:0] i;
        logic [1:0]  st;
        logic [4:0]  sts;
        logic [31:0] ret;
    } vec_t;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    vec_t tbl[$];
    vec_t sb[$];
    control_sequencer_if bus();
    control_sequencer dut (.clock(clock), .reset(reset), .bus(bus));
    always #5 clock = ~clock;
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic add(input logic ack, input logic [31:0] instr, input logic mrdy, input logic [32:0] cw,
                       input logic [4:0] sin, input logic req, input logic ex, input logic [32:0] cwo,
                       input logic [31:0] i, input logic [1:0] st, input logic [4:0] sts, input logic [31:0] ret);
        vec_t v;
        v.ack = ack; v.instr = instr; v.mrdy = mrdy; v.cw = cw; v.sin = sin;
        v.req = req; v.ex = ex; v.cwo = cwo; v.i = i; v.st = st; v.sts = sts; v.ret = ret;
        tbl.push_back(v);
    endtask
    task automatic check_outs(input string tag, input logic req, input logic ex, input logic [32:0] cwo,
                              input logic [31:0] i, input logic [1:0] st, input logic [4:0] sts, input logic [31:0] ret);
        check({tag, " ifetch_req"}, 64'(bus.ifetch_req), 64'(req));
        check({tag, " executing"},  64'(bus.executing),  64'(ex));
        check({tag, " cw_out"},     64'(bus.cw_out),     64'(cwo));
        check({tag, " I"},          64'(bus.I),          64'(i));
        check({tag, " state"},      64'(bus.state),      64'(st));
        check({tag, " status"},     64'(bus.status),     64'(sts));
        check({tag, " retired"},    64'(bus.retired),    64'(ret));
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
    initial begin
        vec_t e;
        // single-cycle instruction
        add(0, 32'h0,        0, CW_A, 5'h00, 0, 0, 33'h0, 32'h0,        2'd0, 5'h00, 0);
        add(1, 32'hF8400000, 1, CW_A, 5'h00, 1, 0, 33'h0, 32'h0,        2'd0, 5'h00, 0);
        add(0, 32'h0,        1, CW_A, 5'h00, 0, 1, CW_A,  32'hF8400000, 2'd0, 5'h00, 0);
        // delayed fetch: five cycles without ack
        for (int k = 0; k < 5; k++)
            add(0, 32'h11111111, 0, CW_L, 5'h1F, 1, 0, 33'h0, 32'hF8400000, 2'd0, 5'h00, 1);
        add(1, 32'h12345678, 0, CW_L, 5'h00, 1, 0, 33'h0, 32'hF8400000, 2'd0, 5'h00, 1);
        // two-cycle instruction; ack in EXEC and mem_ready without ram_en are ignored
        add(1, 32'hDEADBEEF, 0, CW_B, 5'h00, 0, 1, CW_B, 32'h12345678, 2'd0, 5'h00, 1);
        add(0, 32'h0,        0, CW_C, 5'h00, 0, 1, CW_C, 32'h12345678, 2'd1, 5'h00, 1);
        add(1, 32'hA0000000, 1, CW_A, 5'h00, 1, 0, 33'h0, 32'h12345678, 2'd1, 5'h00, 2);
        // load stall for three cycles with status_ld set, then commit
        for (int k = 0; k < 3; k++)
            add(0, 32'h0, 0, CW_L, 5'h16, 0, 1, CW_LS, 32'hA0000000, 2'd0, 5'h00, 2);
        add(0, 32'h0,        1, CW_L, 5'h16, 0, 1, CW_L,  32'hA0000000, 2'd0, 5'h00, 2);
        add(1, 32'h0BADF00D, 0, CW_A, 5'h00, 1, 0, 33'h0, 32'hA0000000, 2'd0, 5'h16, 3);
        add(0, 32'h0,        0, CW_B, 5'h00, 0, 1, CW_B,  32'h0BADF00D, 2'd0, 5'h16, 3);
        bus.ifetch_ack = 0; bus.instr_in = 0; bus.mem_ready = 0; bus.cw_in = CW_A; bus.status_in = 5'h1F;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_outs("in_reset", 0, 0, 33'h0, 32'h0, 2'd0, 5'h00, 0);
        @(posedge clock);
        #1 reset = 1'b0;
        for (int n = 0; n < tbl.size(); n++) begin
            bus.ifetch_ack = tbl[n].ack;
            bus.instr_in   = tbl[n].instr;
            bus.mem_ready  = tbl[n].mrdy;
            bus.cw_in      = tbl[n].cw;
            bus.status_in  = tbl[n].sin;
            sb.push_back(tbl[n]);
            @(negedge clock);
            e = sb.pop_front();
            check_outs($sformatf("vec%0d", n), e.req, e.ex, e.cwo, e.i, e.st, e.sts, e.ret);
            @(posedge clock);
            #1;
        end
        // async reset mid-EXEC with state 01 and a retiring word presented
        bus.ifetch_ack = 0; bus.mem_ready = 1; bus.cw_in = CW_C; bus.status_in = 5'h01;
        #2;
        check("pre_reset executing", 64'(bus.executing), 64'(1));
        check("pre_reset state", 64'(bus.state), 64'(1));
        reset = 1'b1;
        #1;
        check_outs("async_reset", 0, 0, 33'h0, 32'h0, 2'd0, 5'h00, 0);
        @(posedge clock);
        #1;
        check_outs("reset_edge", 0, 0, 33'h0, 32'h0, 2'd0, 5'h00, 0);
        reset = 1'b0;
        @(negedge clock);
        check("boot ifetch_req", 64'(bus.ifetch_req), 64'(0));
        @(posedge clock);
        #1;
        check("post_boot ifetch_req", 64'(bus.ifetch_req), 64'(1));
        check("post_boot cw_out", 64'(bus.cw_out), 64'(0));
        check("scoreboard drained", 64'(sb.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
